// File: rtl/td4_pkg.sv
// Shared TD4 constants plus the program-loader and UART receiver state encodings.
package td4_pkg;

  localparam int unsigned TD4_ROM_DEPTH = 16;
  localparam int unsigned TD4_ADDR_W    = 4;
  localparam int unsigned TD4_WORD_W    = 8;
  localparam logic [7:0]  LOADER_HDR    = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StCsum,
    StDone,
    StErr
  } loader_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/td4_prog_loader_if.sv
// Program-memory write port between the loader (master) and the TD4 core memory (slave).
interface td4_prog_loader_if;

  logic                              prog_we;
  logic [td4_pkg::TD4_ADDR_W-1:0]    prog_addr;
  logic [td4_pkg::TD4_WORD_W-1:0]    prog_data;

  modport master (
    output prog_we,
    output prog_addr,
    output prog_data
  );

  modport slave (
    input prog_we,
    input prog_addr,
    input prog_data
  );

endinterface

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, valid/framing-error pulses.
module uart_rx_byte
  import td4_pkg::*;
#(
  parameter int unsigned BIT_CYC = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int unsigned CNT_W = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] HalfM1 = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0] FullM1 = CNT_W'(BIT_CYC - 1);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (prev_q && !rx_s) state_d = RxStart;
      end
      RxStart: begin
        // A start bit that is high again at half-bit was a glitch.
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RxData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RxStop;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RxStop: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          state_d = RxIdle;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_byte  = shift_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/td4_prog_loader.sv
// Loads a checksummed 16-word program image over UART into TD4 program memory.
// The core's reset_n should be driven as ~(reset | cpu_hold).
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DEPTH      = TD4_ROM_DEPTH,
  parameter int unsigned TIMEOUT_CY = 1_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               uart_rx,
  td4_prog_loader_if.master  prog,
  output logic               cpu_hold,
  output logic               busy,
  output logic               load_ok,
  output logic               load_err
);

  localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CY + 1);
  localparam logic [TD4_ADDR_W-1:0] LastAddr = TD4_ADDR_W'(DEPTH - 1);
  localparam logic [TO_W-1:0]       ToLast   = TO_W'(TIMEOUT_CY - 1);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ferr;

  uart_rx_byte #(
    .BIT_CYC (BIT_CYC)
  ) u_rx (
    .clock    (clock),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

  loader_state_e           state_q, state_d;
  logic [TD4_ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]              sum_q, sum_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic                    we_q, we_d;
  logic [TD4_ADDR_W-1:0]   waddr_q, waddr_d;
  logic [TD4_WORD_W-1:0]   wdata_q, wdata_d;
  logic                    hold_q, hold_d;
  logic                    busy_q, busy_d;
  logic                    ok_q, ok_d;
  logic                    err_q, err_d;
  logic                    timeout;
  logic                    abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      sum_q   <= '0;
      to_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      to_q    <= to_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // The TIMEOUT_CY-th consecutive idle clock since the last byte ends the frame.
  assign timeout = (to_q == ToLast) && !rx_valid;
  assign abort   = rx_ferr || timeout;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    to_d    = to_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    ok_d    = ok_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StErr: begin
        if (rx_valid && rx_byte == LOADER_HDR) begin
          state_d = StData;
          hold_d  = 1'b1;
          busy_d  = 1'b1;
          ok_d    = 1'b0;
          err_d   = 1'b0;
          addr_d  = '0;
          sum_d   = '0;
          to_d    = '0;
        end
      end
      StData: begin
        if (abort) begin
          state_d = StErr;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (rx_valid) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = rx_byte;
          sum_d   = sum_q + rx_byte;
          to_d    = '0;
          if (addr_q == LastAddr) state_d = StCsum;
          else                    addr_d  = addr_q + TD4_ADDR_W'(1);
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      StCsum: begin
        if (abort) begin
          state_d = StErr;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (rx_valid) begin
          to_d   = '0;
          busy_d = 1'b0;
          if (rx_byte == sum_q) begin
            state_d = StDone;
            hold_d  = 1'b0;
            ok_d    = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign prog.prog_we   = we_q;
  assign prog.prog_addr = waddr_q;
  assign prog.prog_data = wdata_q;
  assign cpu_hold       = hold_q;
  assign busy           = busy_q;
  assign load_ok        = ok_q;
  assign load_err       = err_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader with a frame-level reference model and write scoreboard.
module tb_td4_prog_loader;

  localparam int BC = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic cpu_hold, busy, load_ok, load_err;

  td4_prog_loader_if prog ();

  td4_prog_loader #(
    .CLK_HZ     (1600),
    .BAUD       (100),
    .DEPTH      (16),
    .TIMEOUT_CY (400)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .prog     (prog),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .load_ok  (load_ok),
    .load_err (load_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_writes = 0;
  int rxv_cnt = 0;
  logic prev_we = 1'b0;

  logic [7:0] img [16];

  // Reference model: frame rules only, no cycle timing.
  int         m_mode = 0;   // 0 wait header, 1 data, 2 checksum
  int         m_addr = 0;
  logic [7:0] m_sum = 8'h00;
  logic       m_ok = 1'b0, m_err = 1'b0, m_hold = 1'b0, m_busy = 1'b0;
  logic [11:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_fail();
    m_mode = 0;
    m_busy = 1'b0;
    m_err  = 1'b1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_addr = 0; m_sum = 8'h00;
    m_ok = 1'b0; m_err = 1'b0; m_hold = 1'b0; m_busy = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (m_mode == 0) begin
      if (stop_ok && b == 8'hA5) begin
        m_mode = 1; m_addr = 0; m_sum = 8'h00;
        m_hold = 1'b1; m_busy = 1'b1; m_ok = 1'b0; m_err = 1'b0;
      end
    end else if (!stop_ok) begin
      model_fail();
    end else if (m_mode == 1) begin
      exp_q.push_back({m_addr[3:0], b});
      m_sum = m_sum + b;
      if (m_addr == 15) m_mode = 2;
      else m_addr++;
    end else begin
      if (b == m_sum) begin
        m_ok = 1'b1; m_hold = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_busy = 1'b0;
      m_mode = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    model_byte(b, stop);
    @(negedge clock) uart_rx = 1'b0;
    repeat (BC - 1) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock) uart_rx = b[i];
      repeat (BC - 1) @(negedge clock);
    end
    @(negedge clock) uart_rx = stop;
    repeat (BC - 1) @(negedge clock);
    @(negedge clock) uart_rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic send_frame(input string name, input logic [7:0] csum_delta);
    logic [7:0] s;
    s = 8'h00;
    send_byte(8'hA5, 1'b1);
    chk({name, " busy after header"}, busy, 1);
    chk({name, " hold after header"}, cpu_hold, 1);
    for (int i = 0; i < 16; i++) begin
      send_byte(img[i], 1'b1);
      s = s + img[i];
    end
    send_byte(s + csum_delta, 1'b1);
    repeat (20) @(negedge clock);
  endtask

  task automatic check_state(input string name);
    chk({name, " load_ok"}, load_ok, m_ok);
    chk({name, " load_err"}, load_err, m_err);
    chk({name, " cpu_hold"}, cpu_hold, m_hold);
    chk({name, " busy"}, busy, m_busy);
    chk({name, " pending writes"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, " prog_we"}, prog.prog_we, 0);
    chk({name, " prog_addr"}, prog.prog_addr, 0);
    chk({name, " prog_data"}, prog.prog_data, 0);
    chk({name, " cpu_hold"}, cpu_hold, 0);
    chk({name, " busy"}, busy, 0);
    chk({name, " load_ok"}, load_ok, 0);
    chk({name, " load_err"}, load_err, 0);
  endtask

  // Write scoreboard: every strobe must match the next expected write, never back-to-back.
  always @(negedge clock) begin
    if (!reset && prog.prog_we) begin
      n_writes++;
      chk("we back-to-back", prev_we, 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected write: addr %0h data %0h, none expected",
                 prog.prog_addr, prog.prog_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("write addr", prog.prog_addr, e[11:8]);
        chk("write data", prog.prog_data, e[7:0]);
      end
    end
    prev_we = reset ? 1'b0 : prog.prog_we;
    if (dut.rx_valid) rxv_cnt++;
  end

  initial begin
    int rxv0;
    img = '{8'h3C, 8'h36, 8'hA5, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h56,
            8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'h81, 8'hBA};

    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Good frame
    n_writes = 0;
    send_frame("good", 8'h00);
    check_state("good");
    chk("good writes", n_writes, 16);
    chk("good model sum", m_sum, 8'h98);
    chk("good load_ok literal", load_ok, 1);
    chk("good cpu_hold literal", cpu_hold, 0);

    // Checksum off by one
    n_writes = 0;
    send_frame("badsum", 8'h01);
    check_state("badsum");
    chk("badsum writes", n_writes, 16);
    chk("badsum load_err literal", load_err, 1);
    chk("badsum cpu_hold literal", cpu_hold, 1);

    // Leading junk ignored
    n_writes = 0;
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    chk("junk writes", n_writes, 0);
    send_frame("junk", 8'h00);
    check_state("junk");
    chk("junk load_ok literal", load_ok, 1);

    // Framing error on 5th data byte
    n_writes = 0;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(img[i], 1'b1);
    send_byte(img[4], 1'b0);
    repeat (20) @(negedge clock);
    check_state("ferr");
    chk("ferr writes", n_writes, 4);
    chk("ferr load_err literal", load_err, 1);
    send_frame("after ferr", 8'h00);
    check_state("after ferr");
    send_byte(8'h12, 1'b0);
    repeat (20) @(negedge clock);
    check_state("idle ferr");

    // Timeout inside a frame
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(img[i], 1'b1);
    repeat (500) @(negedge clock);
    model_fail();
    check_state("timeout");
    chk("timeout busy literal", busy, 0);
    send_frame("after timeout", 8'h00);
    check_state("after timeout");

    // Reset in the middle of data byte 7
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(img[i], 1'b1);
    @(negedge clock) uart_rx = 1'b0;
    repeat (BC - 1) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock) uart_rx = img[6][i];
      repeat (BC - 1) @(negedge clock);
    end
    repeat (BC / 2) @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock) uart_rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check_reset_vals("midreset");
    n_writes = 0;
    send_frame("after reset", 8'h00);
    check_state("after reset");
    chk("after reset writes", n_writes, 16);

    // One-cycle glitch in idle
    rxv0 = rxv_cnt;
    @(negedge clock) uart_rx = 1'b0;
    @(negedge clock) uart_rx = 1'b1;
    repeat (60) @(negedge clock);
    chk("glitch rx_valid", rxv_cnt - rxv0, 0);
    check_state("glitch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
